lcd_hd44780_driver: RTL and testbench

Physical-layer driver for an HD44780-compatible character LCD in 8-bit write-only mode. It sits directly downstream of the LCD sequencing controller and consumes its enable, function code and data byte. It expands each request into LCD bus cycles with correct setup, E-pulse and execution timing, then returns a one-cycle done pulse. The done pulse drives the controller's i_done_LCD.

---
 rtl/lcd_hd44780_driver_pkg.sv | 37 +++
 rtl/lcd_hd44780_driver_if.sv | 25 ++
 rtl/lcd_hd44780_driver_timer.sv | 27 ++
 rtl/lcd_hd44780_driver.sv | 182 ++++++++++++++++++
 tb/tb_lcd_hd44780_driver.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_hd44780_driver_pkg.sv
// rtl/lcd_hd44780_driver_pkg.sv - shared constants, state enum and helpers for the HD44780 driver
package lcd_pkg;

  localparam logic [3:0] FUNC_INIT      = 4'd0;
  localparam logic [3:0] FUNC_SETCURSOR = 4'd1;
  localparam logic [3:0] FUNC_DATA      = 4'd3;

  localparam logic [7:0] CMD_FUNCSET = 8'h38;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  typedef enum logic [2:0] {
    ST_PWRON,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } drv_state_e;

  // Byte issued at each step of the INIT expansion
  function automatic logic [7:0] init_byte(input logic [1:0] step);
    case (step)
      2'd0:    init_byte = CMD_FUNCSET;
      2'd1:    init_byte = CMD_DISPON;
      2'd2:    init_byte = CMD_CLEAR;
      default: init_byte = CMD_ENTRY;
    endcase
  endfunction

  function automatic int max2(input int a, input int b);
    max2 = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_hd44780_driver_if.sv
// rtl/lcd_hd44780_driver_if.sv - request/response and LCD bus signals between controller and driver
interface lcd_hd44780_driver_if #(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_FUNC = 4
);
  logic                 i_en_lcd;
  logic [SIZE_FUNC-1:0] i_func;
  logic [SIZE_DATA-1:0] i_data;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_lcd_rs;
  logic                 o_lcd_rw;
  logic                 o_lcd_e;
  logic [SIZE_DATA-1:0] o_lcd_data;

  modport master (
    output i_en_lcd, i_func, i_data,
    input  o_busy, o_done, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_data
  );

  modport slave (
    input  i_en_lcd, i_func, i_data,
    output o_busy, o_done, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_data
  );
endinterface

// File: rtl/lcd_hd44780_driver_timer.sv
// rtl/lcd_hd44780_driver_timer.sv - loadable down-counter; expired while the count sits at zero
module lcd_timer #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= RESET_VAL;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/lcd_hd44780_driver.sv
// rtl/lcd_hd44780_driver.sv - HD44780 8-bit write-only bus driver: expands requests into
// timed RS/DB/E cycles and pulses done when the last execution wait ends.
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int SIZE_DATA   = 8,
  parameter int SIZE_FUNC   = 4,
  parameter int T_PWRON_CYC = 750000,
  parameter int T_SETUP_CYC = 2,
  parameter int T_PW_CYC    = 25,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  lcd_hd44780_driver_if.slave   bus
);

  localparam int T_MAX = max2(max2(max2(T_PWRON_CYC, T_SETUP_CYC),
                                   max2(T_PW_CYC, T_CMD_CYC)), T_CLR_CYC);
  localparam int CNT_W = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] LD_PWRON = CNT_W'(T_PWRON_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_CYC - 1);

  drv_state_e           state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rs_q;
  logic                 e_q;
  logic [SIZE_DATA-1:0] db_q;
  logic                 init_q;
  logic [1:0]           step_q;

  logic                 func_ok;
  logic                 last_byte;
  logic                 tmr_load_d;
  logic [CNT_W-1:0]     tmr_val_d;
  logic                 tmr_expired;

  // Timer loads on entry to each timed phase so its count lines up with the state change
  always_comb begin
    func_ok    = (bus.i_func == SIZE_FUNC'(FUNC_INIT)) ||
                 (bus.i_func == SIZE_FUNC'(FUNC_SETCURSOR)) ||
                 (bus.i_func == SIZE_FUNC'(FUNC_DATA));
    last_byte  = !init_q || (step_q == 2'd3);
    tmr_load_d = 1'b0;
    tmr_val_d  = LD_SETUP;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_en_lcd && func_ok) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_expired) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = LD_PW;
        end
      end
      ST_PULSE: begin
        if (tmr_expired) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = (db_q == SIZE_DATA'(CMD_CLEAR)) ? LD_CLR : LD_CMD;
        end
      end
      ST_HOLD: begin
        if (tmr_expired && !last_byte) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = LD_SETUP;
        end
      end
      default: ;
    endcase
  end

  lcd_timer #(
    .W         (CNT_W),
    .RESET_VAL (LD_PWRON)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_PWRON;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      db_q    <= '0;
      init_q  <= 1'b0;
      step_q  <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_PWRON: begin
          if (tmr_expired) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.i_en_lcd) begin
            if (bus.i_func == SIZE_FUNC'(FUNC_INIT)) begin
              state_q <= ST_SETUP;
              busy_q  <= 1'b1;
              init_q  <= 1'b1;
              step_q  <= 2'd0;
              rs_q    <= 1'b0;
              db_q    <= SIZE_DATA'(init_byte(2'd0));
            end else if (bus.i_func == SIZE_FUNC'(FUNC_SETCURSOR)) begin
              state_q <= ST_SETUP;
              busy_q  <= 1'b1;
              init_q  <= 1'b0;
              rs_q    <= 1'b0;
              db_q    <= SIZE_DATA'(CMD_DDRAM | {1'b0, bus.i_data[6:0]});
            end else if (bus.i_func == SIZE_FUNC'(FUNC_DATA)) begin
              state_q <= ST_SETUP;
              busy_q  <= 1'b1;
              init_q  <= 1'b0;
              rs_q    <= 1'b1;
              db_q    <= bus.i_data;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_expired) begin
            state_q <= ST_PULSE;
            e_q     <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (tmr_expired) begin
            state_q <= ST_HOLD;
            e_q     <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (tmr_expired) begin
            if (last_byte) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_SETUP;
              step_q  <= step_q + 2'd1;
              db_q    <= SIZE_DATA'(init_byte(step_q + 2'd1));
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          e_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_lcd_rs   = rs_q;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_e    = e_q;
  assign bus.o_lcd_data = db_q;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// tb/tb_lcd_hd44780_driver.sv - directed self-checking bench for lcd_hd44780_driver
module tb_lcd_hd44780_driver;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_assert;
  int   n_fail;

  int       n_rise;
  int       n_fall;
  int       n_done;
  logic     e_prev;
  int       rise_cyc [16];
  logic [7:0] rise_db [16];
  logic     rise_rs  [16];
  int       fall_cyc [16];

  int         exp_rise [4] = '{23, 39, 55, 91};
  int         exp_fall [4] = '{27, 43, 59, 95};
  logic [7:0] exp_db   [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_hd44780_driver_if #(.SIZE_DATA(8), .SIZE_FUNC(4)) bus_if ();

  lcd_hd44780_driver #(
    .SIZE_DATA   (8),
    .SIZE_FUNC   (4),
    .T_PWRON_CYC (20),
    .T_SETUP_CYC (2),
    .T_PW_CYC    (4),
    .T_CMD_CYC   (10),
    .T_CLR_CYC   (30)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    n_rise = 0;
    n_fall = 0;
    n_done = 0;
    e_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (bus_if.o_lcd_e && !e_prev && n_rise < 16) begin
      rise_cyc[n_rise] = cyc;
      rise_db[n_rise]  = bus_if.o_lcd_data;
      rise_rs[n_rise]  = bus_if.o_lcd_rs;
      n_rise++;
    end
    if (!bus_if.o_lcd_e && e_prev && n_fall < 16) begin
      fall_cyc[n_fall] = cyc;
      n_fall++;
    end
    e_prev = bus_if.o_lcd_e;
    if (bus_if.o_done) n_done++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int k);
    int g;
    g = 0;
    while (cyc < k && g < 1000) begin
      @(negedge clk);
      g++;
    end
    #1;
    if (cyc != k) begin
      n_assert++;
      n_fail++;
      $error("FAIL goto: observed cycle %0d expected %0d", cyc, k);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_if.i_en_lcd = 1'b1;
    bus_if.i_func   = 4'd0;
    bus_if.i_data   = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus_if.o_busy, 1'b1);
    chk("rst_done", bus_if.o_done, 1'b0);
    chk("rst_rs", bus_if.o_lcd_rs, 1'b0);
    chk("rst_rw", bus_if.o_lcd_rw, 1'b0);
    chk("rst_e", bus_if.o_lcd_e, 1'b0);
    chk("rst_data", bus_if.o_lcd_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-on wait with a request held high: ignored until IDLE
    goto(1);
    chk("pwron_busy_c1", bus_if.o_busy, 1'b1);
    goto(19);
    chk("pwron_busy_c19", bus_if.o_busy, 1'b1);
    chk("pwron_no_e", n_rise, 0);
    goto(20);
    chk("idle_busy", bus_if.o_busy, 1'b0);
    chk("idle_e", bus_if.o_lcd_e, 1'b0);

    // INIT accepted at cycle 20
    goto(21);
    bus_if.i_en_lcd = 1'b0;
    chk("init_busy", bus_if.o_busy, 1'b1);
    chk("init_db0", bus_if.o_lcd_data, 8'h38);
    chk("init_rs0", bus_if.o_lcd_rs, 1'b0);
    chk("init_setup_e", bus_if.o_lcd_e, 1'b0);
    goto(104);
    chk("init_done_early", bus_if.o_done, 1'b0);
    chk("init_busy_late", bus_if.o_busy, 1'b1);
    goto(105);
    chk("init_done", bus_if.o_done, 1'b1);
    chk("init_done_busy", bus_if.o_busy, 1'b0);
    goto(106);
    chk("init_done_one", bus_if.o_done, 1'b0);
    chk("init_ndone", n_done, 1);
    chk("init_nrise", n_rise, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("init_rise%0d", i), rise_cyc[i], exp_rise[i]);
      chk($sformatf("init_fall%0d", i), fall_cyc[i], exp_fall[i]);
      chk($sformatf("init_db%0d", i), rise_db[i], exp_db[i]);
      chk($sformatf("init_rs%0d", i), rise_rs[i], 1'b0);
    end

    // SETCURSOR 0x45 accepted at cycle 106
    bus_if.i_en_lcd = 1'b1;
    bus_if.i_func   = 4'd1;
    bus_if.i_data   = 8'h45;
    goto(107);
    bus_if.i_en_lcd = 1'b0;
    bus_if.i_data   = 8'h12;
    chk("cur_busy", bus_if.o_busy, 1'b1);
    chk("cur_db", bus_if.o_lcd_data, 8'hC5);
    chk("cur_rs", bus_if.o_lcd_rs, 1'b0);
    goto(122);
    chk("cur_done_early", bus_if.o_done, 1'b0);
    goto(123);
    chk("cur_done", bus_if.o_done, 1'b1);
    goto(124);
    chk("cur_nrise", n_rise, 5);
    chk("cur_rise", rise_cyc[4], 109);
    chk("cur_fall", fall_cyc[4], 113);
    chk("cur_rise_db", rise_db[4], 8'hC5);
    chk("cur_idle", bus_if.o_busy, 1'b0);

    // DATA 0x41 accepted at cycle 124; inputs change mid-operation
    bus_if.i_en_lcd = 1'b1;
    bus_if.i_func   = 4'd3;
    bus_if.i_data   = 8'h41;
    goto(125);
    bus_if.i_en_lcd = 1'b0;
    bus_if.i_data   = 8'hFF;
    bus_if.i_func   = 4'd1;
    chk("dat_setup_rs", bus_if.o_lcd_rs, 1'b1);
    chk("dat_setup_db", bus_if.o_lcd_data, 8'h41);
    goto(128);
    chk("dat_pulse_e", bus_if.o_lcd_e, 1'b1);
    chk("dat_pulse_db", bus_if.o_lcd_data, 8'h41);
    chk("dat_pulse_rs", bus_if.o_lcd_rs, 1'b1);
    goto(135);
    chk("dat_hold_e", bus_if.o_lcd_e, 1'b0);
    chk("dat_hold_db", bus_if.o_lcd_data, 8'h41);
    chk("dat_hold_rs", bus_if.o_lcd_rs, 1'b1);
    goto(140);
    chk("dat_done_early", bus_if.o_done, 1'b0);
    goto(141);
    chk("dat_done", bus_if.o_done, 1'b1);
    goto(142);
    chk("dat_rise", rise_cyc[5], 127);
    chk("dat_nrise", n_rise, 6);
    chk("dat_ndone", n_done, 3);

    // Unsupported func 7, held high for a back-to-back re-accept
    bus_if.i_en_lcd = 1'b1;
    bus_if.i_func   = 4'd7;
    goto(143);
    chk("bad_done", bus_if.o_done, 1'b1);
    chk("bad_busy", bus_if.o_busy, 1'b0);
    chk("bad_e", bus_if.o_lcd_e, 1'b0);
    goto(144);
    chk("bad_idle_done", bus_if.o_done, 1'b0);
    chk("bad_idle_busy", bus_if.o_busy, 1'b0);
    goto(145);
    bus_if.i_en_lcd = 1'b0;
    chk("bad_reaccept_done", bus_if.o_done, 1'b1);
    goto(146);
    chk("bad_done_clear", bus_if.o_done, 1'b0);
    chk("bad_nrise", n_rise, 6);
    chk("bad_ndone", n_done, 5);

    // Reset asserted while E is high
    bus_if.i_en_lcd = 1'b1;
    bus_if.i_func   = 4'd3;
    bus_if.i_data   = 8'h5A;
    goto(147);
    bus_if.i_en_lcd = 1'b0;
    goto(150);
    chk("rr_e_high", bus_if.o_lcd_e, 1'b1);
    chk("rr_db", bus_if.o_lcd_data, 8'h5A);
    rst_n = 1'b0;
    #1;
    chk("rr_e_async", bus_if.o_lcd_e, 1'b0);
    chk("rr_busy", bus_if.o_busy, 1'b1);
    chk("rr_data", bus_if.o_lcd_data, 8'h00);
    chk("rr_rs", bus_if.o_lcd_rs, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    goto(19);
    chk("rr_pwron_busy", bus_if.o_busy, 1'b1);
    goto(20);
    chk("rr_idle_busy", bus_if.o_busy, 1'b0);
    chk("rr_nrise", n_rise, 7);
    chk("rr_ndone", n_done, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
